// File: rtl/priority_arbiter_if.sv
// Request/grant bundle between N requesters and the arbiter.
// The arbiter binds to the slave modport; the request side drives the master modport.
interface priority_arbiter_if #(
    parameter int N = 4
) ();
    localparam int IDXW = $clog2(N);

    logic [N-1:0]    i_req;
    logic            i_ready;
    logic            o_valid;
    logic [N-1:0]    o_grant;
    logic [IDXW-1:0] o_index;

    modport slave (
        input  i_req,
        input  i_ready,
        output o_valid,
        output o_grant,
        output o_index
    );

    modport master (
        output i_req,
        output i_ready,
        input  o_valid,
        input  o_grant,
        input  o_index
    );
endinterface

// File: rtl/priority_arbiter.sv
// Registered N-way arbiter, fixed or round-robin priority, grant held until accepted.
// Selection is a rotate-then-find-lowest scan so any N (power of two or not) wraps correctly.
module priority_arbiter #(
    parameter  int N    = 4,
    parameter  int MODE = 0,
    localparam int IDXW = $clog2(N)
) (
    input logic               i_clock,
    input logic               i_aresetn,
    priority_arbiter_if.slave bus
);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t          state, state_nxt;
    logic [N-1:0]    grant_q, grant_nxt;
    logic [IDXW-1:0] index_q, index_nxt;
    logic [IDXW-1:0] ptr, ptr_nxt;

    logic            handshake;
    logic [IDXW-1:0] adv_ptr;
    logic [N-1:0]    cand;
    logic [IDXW-1:0] base;
    logic [N-1:0]    rot;
    logic [IDXW-1:0] off;
    logic            found;
    logic [IDXW:0]   sum;
    logic [IDXW-1:0] sel_idx;

    assign handshake = (state == GRANT) && bus.i_ready;
    assign adv_ptr   = (index_q == IDXW'(N - 1)) ? '0 : index_q + 1'b1;

    // On a transfer the round-robin scan starts just past the winner, which
    // is then excluded unless it is the only requester left.
    always_comb begin
        cand = bus.i_req;
        base = '0;
        if (MODE == 1) begin
            base = handshake ? adv_ptr : ptr;
            if (handshake && ((bus.i_req & ~grant_q) != '0))
                cand = bus.i_req & ~grant_q;
        end
    end

    always_comb begin
        rot   = N'({cand, cand} >> base);
        found = |rot;
        off   = '0;
        for (int j = N - 1; j >= 0; j--)
            if (rot[j]) off = IDXW'(j);
    end

    assign sum     = {1'b0, base} + {1'b0, off};
    assign sel_idx = (sum >= (IDXW + 1)'(N)) ? IDXW'(sum - (IDXW + 1)'(N)) : IDXW'(sum);

    always_comb begin
        state_nxt = state;
        grant_nxt = grant_q;
        index_nxt = index_q;
        ptr_nxt   = ptr;
        case (state)
            IDLE: begin
                if (found) begin
                    state_nxt = GRANT;
                    grant_nxt = {{(N-1){1'b0}}, 1'b1} << sel_idx;
                    index_nxt = sel_idx;
                end
            end
            GRANT: begin
                if (bus.i_ready) begin
                    if (MODE == 1) ptr_nxt = adv_ptr;
                    if (found) begin
                        grant_nxt = {{(N-1){1'b0}}, 1'b1} << sel_idx;
                        index_nxt = sel_idx;
                    end else begin
                        state_nxt = IDLE;
                        grant_nxt = '0;
                        index_nxt = '0;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                grant_nxt = '0;
                index_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge i_clock or negedge i_aresetn) begin
        if (!i_aresetn) begin
            state   <= IDLE;
            grant_q <= '0;
            index_q <= '0;
            ptr     <= '0;
        end else begin
            state   <= state_nxt;
            grant_q <= grant_nxt;
            index_q <= index_nxt;
            ptr     <= ptr_nxt;
        end
    end

    assign bus.o_valid = (state == GRANT);
    assign bus.o_grant = grant_q;
    assign bus.o_index = index_q;

endmodule

// File: tb/tb_priority_arbiter.sv
// Bench for priority_arbiter: fixed N=4, round-robin N=4 and round-robin N=5 instances
// checked every cycle against a queue-free index model plus directed literal expectations.
module tb_priority_arbiter;

    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    priority_arbiter_if #(.N(4)) b0 ();
    priority_arbiter_if #(.N(4)) b1 ();
    priority_arbiter_if #(.N(5)) b2 ();

    priority_arbiter #(.N(4), .MODE(0)) u0 (.i_clock(clk), .i_aresetn(rst_n), .bus(b0.slave));
    priority_arbiter #(.N(4), .MODE(1)) u1 (.i_clock(clk), .i_aresetn(rst_n), .bus(b1.slave));
    priority_arbiter #(.N(5), .MODE(1)) u2 (.i_clock(clk), .i_aresetn(rst_n), .bus(b2.slave));

    logic [7:0] m_req   [3];
    logic       m_rdy   [3];
    logic       d_valid [3];
    logic [7:0] d_grant [3];
    logic [7:0] d_idx   [3];

    assign m_req[0]   = {4'b0, b0.i_req};
    assign m_req[1]   = {4'b0, b1.i_req};
    assign m_req[2]   = {3'b0, b2.i_req};
    assign m_rdy[0]   = b0.i_ready;
    assign m_rdy[1]   = b1.i_ready;
    assign m_rdy[2]   = b2.i_ready;
    assign d_valid[0] = b0.o_valid;
    assign d_valid[1] = b1.o_valid;
    assign d_valid[2] = b2.o_valid;
    assign d_grant[0] = {4'b0, b0.o_grant};
    assign d_grant[1] = {4'b0, b1.o_grant};
    assign d_grant[2] = {3'b0, b2.o_grant};
    assign d_idx[0]   = {6'b0, b0.o_index};
    assign d_idx[1]   = {6'b0, b1.o_index};
    assign d_idx[2]   = {5'b0, b2.o_index};

    function automatic int inst_n(input int i);
        return (i == 2) ? 5 : 4;
    endfunction

    function automatic int inst_mode(input int i);
        return (i == 0) ? 0 : 1;
    endfunction

    // first requester found walking start, start+1, ... modulo n
    function automatic int first_from(input logic [7:0] v, input int start, input int n);
        for (int j = 0; j < n; j++) begin
            int k;
            k = (start + j) % n;
            if (v[k]) return k;
        end
        return 0;
    endfunction

    // model: granted flag, granted index, round-robin pointer per instance
    bit mv [3];
    int mi [3];
    int mp [3];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                mv[i] <= 1'b0;
                mi[i] <= 0;
                mp[i] <= 0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                int n, p;
                logic [7:0] cand, own;
                n = inst_n(i);
                if (!mv[i]) begin
                    if (m_req[i] != 8'd0) begin
                        mv[i] <= 1'b1;
                        mi[i] <= first_from(m_req[i], mp[i], n);
                    end
                end else if (m_rdy[i]) begin
                    p    = (inst_mode(i) == 1) ? (mi[i] + 1) % n : 0;
                    own  = 8'd1 << mi[i];
                    cand = m_req[i];
                    if (inst_mode(i) == 1 && (cand & ~own) != 8'd0) cand = cand & ~own;
                    mp[i] <= p;
                    if (cand != 8'd0) mi[i] <= first_from(cand, p, n);
                    else begin
                        mv[i] <= 1'b0;
                        mi[i] <= 0;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            logic [7:0] eg, ei;
            eg = mv[i] ? (8'd1 << mi[i]) : 8'd0;
            ei = mv[i] ? 8'(mi[i]) : 8'd0;
            n_cmp++;
            if (d_valid[i] !== mv[i]) begin
                n_err++;
                $display("FAIL model_valid[%0d] t=%0t got %b want %b", i, $time, d_valid[i], mv[i]);
            end
            n_cmp++;
            if (d_grant[i] !== eg) begin
                n_err++;
                $display("FAIL model_grant[%0d] t=%0t got %b want %b", i, $time, d_grant[i], eg);
            end
            n_cmp++;
            if (d_idx[i] !== ei) begin
                n_err++;
                $display("FAIL model_index[%0d] t=%0t got %0d want %0d", i, $time, d_idx[i], ei);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s t=%0t got %0d want %0d", name, $time, act, exp);
        end
    endtask

    logic [4:0] tv_req [12] = '{5'b01011, 5'b01011, 5'b10110, 5'b00000, 5'b11111, 5'b11111,
                                5'b00100, 5'b10001, 5'b01110, 5'b00000, 5'b11001, 5'b00110};
    logic       tv_rdy [12] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1,
                                1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};

    initial begin
        rst_n = 1'b0;
        b0.i_req = '0; b0.i_ready = 1'b0;
        b1.i_req = '0; b1.i_ready = 1'b0;
        b2.i_req = '0; b2.i_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_valid0", 32'(b0.o_valid), 0);
        chk("reset_grant1", 32'(b1.o_grant), 0);
        chk("reset_index2", 32'(b2.o_index), 0);
        rst_n = 1'b1;

        // fixed priority: lowest set bit, requester 0 may win repeatedly
        b0.i_req = 4'b1110; b0.i_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("fixed_1110_index", 32'(b0.o_index), 1);
            chk("fixed_1110_valid", 32'(b0.o_valid), 1);
        end
        b0.i_req = 4'b1111;
        @(negedge clk); chk("fixed_1111_index", 32'(b0.o_index), 0);
        @(negedge clk); chk("fixed_repeat0_index", 32'(b0.o_index), 0);

        // drain to idle
        b0.i_req = 4'b0010;
        @(negedge clk); chk("drain_index", 32'(b0.o_index), 1);
        b0.i_req = 4'b0000;
        @(negedge clk);
        chk("drain_valid", 32'(b0.o_valid), 0);
        chk("drain_grant", 32'(b0.o_grant), 0);
        chk("drain_index0", 32'(b0.o_index), 0);

        // round-robin fairness
        b1.i_req = 4'b1111; b1.i_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("rr_index", 32'(b1.o_index), 32'(k % 4));
            chk("rr_valid", 32'(b1.o_valid), 1);
        end
        b1.i_req = 4'b0000;
        @(negedge clk); chk("rr_idle_valid", 32'(b1.o_valid), 0);

        // stall and lock, then wrap from pointer 3
        b1.i_ready = 1'b0; b1.i_req = 4'b0100;
        @(negedge clk); chk("stall_grant_first", 32'(b1.o_grant), 32'h4);
        b1.i_req = 4'b0011;
        repeat (3) begin
            @(negedge clk); chk("stall_grant_held", 32'(b1.o_grant), 32'h4);
        end
        b1.i_ready = 1'b1;
        @(negedge clk); chk("stall_release_index", 32'(b1.o_index), 0);
        b1.i_req = 4'b0000;
        @(negedge clk); chk("stall_idle_valid", 32'(b1.o_valid), 0);

        // non-power-of-two wrap
        b2.i_req = 5'b10001; b2.i_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("n5_wrap_index", 32'(b2.o_index), (k % 2 == 0) ? 0 : 4);
        end
        b2.i_req = 5'b00000;
        @(negedge clk); chk("n5_idle_valid", 32'(b2.o_valid), 0);

        // mixed vectors across all instances, checked by the model
        for (int k = 0; k < 12; k++) begin
            b0.i_req = tv_req[k][3:0]; b0.i_ready = tv_rdy[k];
            b1.i_req = tv_req[k][3:0]; b1.i_ready = tv_rdy[k];
            b2.i_req = tv_req[k];      b2.i_ready = tv_rdy[k];
            @(negedge clk);
        end
        b0.i_req = '0; b0.i_ready = 1'b1;
        b1.i_req = '0; b1.i_ready = 1'b1;
        b2.i_req = '0; b2.i_ready = 1'b1;
        repeat (2) @(negedge clk);

        // asynchronous reset mid-grant
        b1.i_req = 4'b0100; b1.i_ready = 1'b0;
        @(negedge clk); chk("prereset_index", 32'(b1.o_index), 2);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_valid", 32'(b1.o_valid), 0);
        chk("async_reset_grant", 32'(b1.o_grant), 0);
        chk("async_reset_index", 32'(b1.o_index), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk); chk("post_reset_grant", 32'(b1.o_grant), 32'h4);
        b1.i_req = 4'b1011; b1.i_ready = 1'b1;
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
